// File: rtl/mem_port_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : mem_port_arbiter                                             |
// | Description : Shares one memory access port between an instruction-fetch  |
// |               requester and a data (load/store) requester. One access is   |
// |               in flight at a time. Each access passes through three        |
// |               phases: arbitrate (IDLE), drive the command (ISSUE) and      |
// |               acknowledge (ACK). Data wins ties, except that an            |
// |               instruction requester that has lost STARVE_LIMIT ties in a   |
// |               row wins the next one.                                       |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
// | Ports                                                                      |
// |   clk          system clock, all logic on rising edge                      |
// |   reset        synchronous, active-high reset                              |
// |   InstReq/InstAdd          fetch request (held until InstAck) + address    |
// |   InstAck/InstData         one-cycle ack pulse + fetched word              |
// |   DataReq/DataWe/DataMemType/DataAdd/DataWData                             |
// |                            data request (held until DataAck); we, type    |
// |                            and wdata are sampled at grant                  |
// |   DataAck/DataRData        one-cycle ack pulse + read data                 |
// |   MemAdd/MemWData/MemReadEn/MemWriteEn/MemType/MemReadData                 |
// |                            memory port                                     |
// |   Busy         high whenever the arbiter is not idle                       |
// +----------------------------------------------------------------------------+
module mem_port_arbiter #(
    parameter int READ_LATENCY = 0,
    parameter int STARVE_LIMIT = 4,
    parameter int ADDR_WIDTH   = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    // instruction-fetch requester
    input  logic                  InstReq,
    input  logic [ADDR_WIDTH-1:0] InstAdd,
    output logic                  InstAck,
    output logic [31:0]           InstData,
    // data requester
    input  logic                  DataReq,
    input  logic                  DataWe,
    input  logic                  DataMemType,
    input  logic [ADDR_WIDTH-1:0] DataAdd,
    input  logic [31:0]           DataWData,
    output logic                  DataAck,
    output logic [31:0]           DataRData,
    // memory port
    output logic [ADDR_WIDTH-1:0] MemAdd,
    output logic [31:0]           MemWData,
    output logic                  MemReadEn,
    output logic                  MemWriteEn,
    output logic                  MemType,
    input  logic [31:0]           MemReadData,
    // status
    output logic                  Busy
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    // Counter widths never collapse to zero bits, even for a zero parameter.
    localparam int C_LAT_W  = (READ_LATENCY > 0) ? $clog2(READ_LATENCY + 1) : 1;
    localparam int C_WAIT_W = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;

    localparam logic [C_LAT_W-1:0]  C_LAT_INIT = C_LAT_W'(READ_LATENCY);
    localparam logic [C_WAIT_W-1:0] C_WAIT_MAX = C_WAIT_W'(STARVE_LIMIT);
    localparam logic [C_LAT_W-1:0]  C_LAT_ONE  = C_LAT_W'(1);
    localparam logic [C_WAIT_W-1:0] C_WAIT_ONE = C_WAIT_W'(1);

    localparam logic [1:0] C_ST_IDLE  = 2'd0;
    localparam logic [1:0] C_ST_ISSUE = 2'd1;
    localparam logic [1:0] C_ST_ACK   = 2'd2;

    // ------------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------------
    logic [1:0]            r_state;
    logic [1:0]            w_next_state;

    logic [ADDR_WIDTH-1:0] r_mem_add;
    logic [31:0]           r_mem_wdata;
    logic                  r_mem_type;
    logic                  r_we;        // command of the access in flight is a write
    logic                  r_sel_data;  // 1 = data requester owns the access in flight
    logic [C_LAT_W-1:0]    r_lat_cnt;   // ISSUE cycles left before read data is valid
    logic [C_WAIT_W-1:0]   r_inst_wait; // consecutive ties lost by the fetch side
    logic [31:0]           r_inst_data;
    logic [31:0]           r_data_rdata;

    logic                  w_grant_inst;
    logic                  w_grant_data;
    logic                  w_inst_lost;
    logic                  w_capture;
    logic                  w_issue;

    // ------------------------------------------------------------------------
    // Next-state and grant decode
    // ------------------------------------------------------------------------
    always_comb begin
        w_next_state = r_state;
        w_grant_inst = 1'b0;
        w_grant_data = 1'b0;
        w_capture    = 1'b0;

        case (r_state)
            C_ST_IDLE: begin
                // Fetch wins when alone, or on a tie once it has been starved.
                if (InstReq && (!DataReq || (r_inst_wait == C_WAIT_MAX))) begin
                    w_grant_inst = 1'b1;
                end else if (DataReq) begin
                    w_grant_data = 1'b1;
                end
                if (w_grant_inst || w_grant_data) begin
                    w_next_state = C_ST_ISSUE;
                end
            end

            C_ST_ISSUE: begin
                // A write needs only its single strobe cycle; a read waits
                // for the latency counter to expire and captures the data.
                if (r_we) begin
                    w_next_state = C_ST_ACK;
                end else if (r_lat_cnt == '0) begin
                    w_capture    = 1'b1;
                    w_next_state = C_ST_ACK;
                end
            end

            C_ST_ACK: begin
                w_next_state = C_ST_IDLE;
            end

            default: begin
                w_next_state = C_ST_IDLE;
            end
        endcase
    end

    // The fetch side lost a tie exactly when both asked and data was granted.
    assign w_inst_lost = w_grant_data && InstReq;

    // ------------------------------------------------------------------------
    // Sequential logic
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= C_ST_IDLE;
            r_mem_add    <= '0;
            r_mem_wdata  <= '0;
            r_mem_type   <= 1'b0;
            r_we         <= 1'b0;
            r_sel_data   <= 1'b0;
            r_lat_cnt    <= '0;
            r_inst_wait  <= '0;
            r_inst_data  <= '0;
            r_data_rdata <= '0;
        end else begin
            r_state <= w_next_state;

            // Command latch: the memory port reflects these registers
            // directly, so they stay stable for the whole ISSUE phase and
            // keep their last value while idle.
            if (w_grant_inst) begin
                r_mem_add  <= InstAdd;
                r_mem_type <= 1'b0;
                r_we       <= 1'b0;
                r_sel_data <= 1'b0;
                r_lat_cnt  <= C_LAT_INIT;
            end else if (w_grant_data) begin
                r_mem_add   <= DataAdd;
                r_mem_type  <= DataMemType;
                r_mem_wdata <= DataWData;
                r_we        <= DataWe;
                r_sel_data  <= 1'b1;
                r_lat_cnt   <= C_LAT_INIT;
            end else if ((r_state == C_ST_ISSUE) && (r_lat_cnt != '0)) begin
                r_lat_cnt <= r_lat_cnt - C_LAT_ONE;
            end

            // Starvation counter: cleared by a fetch grant, saturating count
            // of lost ties otherwise.
            if (w_grant_inst) begin
                r_inst_wait <= '0;
            end else if (w_inst_lost && (r_inst_wait != C_WAIT_MAX)) begin
                r_inst_wait <= r_inst_wait + C_WAIT_ONE;
            end

            // Read data lands in the owner's register and is held there
            // until that requester's next read completes.
            if (w_capture) begin
                if (r_sel_data) begin
                    r_data_rdata <= MemReadData;
                end else begin
                    r_inst_data <= MemReadData;
                end
            end
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign w_issue    = (r_state == C_ST_ISSUE);

    // Writes leave ISSUE after one cycle, so the strobe is a single pulse.
    assign MemReadEn  = w_issue && !r_we;
    assign MemWriteEn = w_issue && r_we;
    assign MemAdd     = r_mem_add;
    assign MemWData   = r_mem_wdata;
    assign MemType    = r_mem_type;

    assign InstAck    = (r_state == C_ST_ACK) && !r_sel_data;
    assign DataAck    = (r_state == C_ST_ACK) && r_sel_data;
    assign InstData   = r_inst_data;
    assign DataRData  = r_data_rdata;

    assign Busy       = (r_state != C_ST_IDLE);

endmodule
`default_nettype wire
